// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: RV32I program counter and IF/ID pipeline register.
// The update order is reset, then branch redirect with flush, then stall hold, then normal fetch.
module riscv_fetch_stage #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid
);
    logic [XLEN-1:0] pc_q, pc_d, ifid_pc_q, ifid_pc_d, ifid_pc4_q, ifid_pc4_d, pc_plus4;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;

    assign pc_plus4 = pc_q + XLEN'(4);

    // A redirect leaves ifid_pc/ifid_pc_plus4 untouched; only the instruction and valid flag are flushed.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (branch_taken) begin
            pc_d         = {branch_target[XLEN-1:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_q;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= XLEN'(4);
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc4_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_valid    = ifid_valid_q;
endmodule

// File: tb/tb_riscv_fetch_stage.sv
// tb_riscv_fetch_stage: directed fetch/stall/redirect/reset scenarios checked against a fetch-stream model.
// A second instance with RESET_PC near the top of memory exercises PC wraparound.
module tb_riscv_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_addr, imem_rdata, pc, ifid_pc, ifid_pc_plus4, ifid_instr;
    logic        ifid_valid;
    logic [31:0] imem_addr2, imem_rdata2, pc2, ifid_pc2, ifid_pc_plus42, ifid_instr2;
    logic        ifid_valid2;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
    logic        m_valid;
    logic        model_ok = 1'b0;

    always #5 clk = ~clk;

    // Instruction memory returns its own address as the instruction word.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a;
    endfunction

    assign imem_rdata  = mem(imem_addr);
    assign imem_rdata2 = mem(imem_addr2);

    riscv_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .pc(pc), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
    );

    riscv_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .branch_taken(1'b0),
        .branch_target(32'h0), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .pc(pc2), .ifid_pc(ifid_pc2), .ifid_pc_plus4(ifid_pc_plus42),
        .ifid_instr(ifid_instr2), .ifid_valid(ifid_valid2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the fetch stream as seen by decode, advanced once per clock.
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h4; m_instr = 32'h13; m_valid = 1'b0;
            model_ok = 1'b1;
        end else if (branch_taken) begin
            m_pc = branch_target & ~32'h3; m_instr = 32'h13; m_valid = 1'b0;
        end else if (!stall) begin
            m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = mem(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("pc", pc, m_pc);
            check("imem_addr", imem_addr, m_pc);
            check("ifid_pc", ifid_pc, m_ipc);
            check("ifid_pc_plus4", ifid_pc_plus4, m_ipc4);
            check("ifid_instr", ifid_instr, m_instr);
            check("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_instr"}, ifid_instr, 32'h13);
        check({tag, "_ifid_pc"}, ifid_pc, 32'h0);
        check({tag, "_pc4"}, ifid_pc_plus4, 32'h4);
        check({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
    endtask

    initial begin
        tick(); tick();
        check_reset("rst0");
        check("wrap_rst_pc", pc2, 32'hFFFF_FFF8);
        rst = 1'b0;
        tick();
        check("run1_pc", pc, 32'h4);
        check("run1_instr", ifid_instr, 32'h0);
        check("run1_valid", {31'b0, ifid_valid}, 32'h1);
        check("wrap1_pc", pc2, 32'hFFFF_FFFC);
        tick();
        check("run2_instr", ifid_instr, 32'h4);
        check("run2_pc4", ifid_pc_plus4, 32'h8);
        check("wrap2_pc", pc2, 32'h0);
        check("wrap2_ifid_pc", ifid_pc2, 32'hFFFF_FFFC);
        check("wrap2_pc4", ifid_pc_plus42, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", pc, 32'h8);
            check("stall_instr", ifid_instr, 32'h4);
        end
        stall = 1'b0;
        tick();
        check("rel1_instr", ifid_instr, 32'h8);
        tick();
        check("rel2_instr", ifid_instr, 32'hC);
        check("rel2_pc", pc, 32'h10);
        branch_taken = 1'b1; branch_target = 32'h40;
        tick();
        check("br_pc", pc, 32'h40);
        check("br_instr", ifid_instr, 32'h13);
        check("br_valid", {31'b0, ifid_valid}, 32'h0);
        check("br_ifid_pc_hold", ifid_pc, 32'hC);
        branch_taken = 1'b0;
        tick();
        check("br_tgt_instr", ifid_instr, 32'h40);
        check("br_tgt_valid", {31'b0, ifid_valid}, 32'h1);
        branch_taken = 1'b1; stall = 1'b1; branch_target = 32'h103;
        tick();
        check("brst_pc", pc, 32'h100);
        check("brst_instr", ifid_instr, 32'h13);
        check("brst_valid", {31'b0, ifid_valid}, 32'h0);
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        check("brst_tgt_instr", ifid_instr, 32'h100);
        tick();
        stall = 1'b1;
        tick();
        check("pre_rst_valid", {31'b0, ifid_valid}, 32'h1);
        rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        check_reset("rst1");
        rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
        tick();
        check("post_rst_instr", ifid_instr, 32'h0);
        check("post_rst_valid", {31'b0, ifid_valid}, 32'h1);
        tick(); tick();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
